led_slot_arbiter: RTL and testbench

Shares the four active-low FPGA status LEDs between up to NREQ on-chip requesters, for example a kernel-clock heartbeat, a DDR calibration flag and a kernel-busy indicator. Grants are time-sliced round-robin; each owner drives the LEDs for at least one full slot while others wait. A one-cycle blank separates owners so that hand-overs are visible. The block sits in the top level between the status sources and the `fpga_led_output` pins, in the `kernel_clk` or `fpga_clk_50` domain.

---
 rtl/led_slot_arbiter.sv | 143 ++++++++++++++
 tb/tb_led_slot_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_slot_arbiter.sv
// Time-sliced round-robin owner of the four active-low status LEDs among NREQ requesters.
// Optional IDLE heartbeat on led_n[3] when LED_SLOT_HEARTBEAT_EN is defined.
module led_slot_arbiter #(
   parameter int NREQ        = 4,
   parameter int SLOT_CYCLES = 50000000
) (
   input  logic              clk,
   input  logic              fpga_reset_n,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] pattern_in,
   output logic [NREQ-1:0]   grant,
   output logic [3:0]        led_n,
   output logic              busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_SWITCH
   } state_t;

   state_t          state_reg;
   logic [IW-1:0]   owner_reg;
   logic [IW-1:0]   last_reg;
   logic [CW-1:0]   cnt_reg;

   logic [3:0]      pat [NREQ];
   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic            others_req;
   logic            slot_end;
   logic [3:0]      idle_led;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_pat
         assign pat[gi] = pattern_in[4*gi +: 4];
      end
   endgenerate

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Rotating search: the first requester after last_reg wins, last_reg itself comes last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last_reg) + k) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // grant is one-hot on the owner while holding, so it masks the owner out.
   assign others_req = (req & ~grant) != '0;
   assign slot_end   = (cnt_reg == CNT_LAST);

`ifdef LED_SLOT_HEARTBEAT_EN
   logic [CW-1:0] hb_cnt_reg;
   logic          toggle_reg;

   always_ff @(posedge clk or negedge fpga_reset_n) begin
      if (!fpga_reset_n) begin
         hb_cnt_reg <= '0;
         toggle_reg <= 1'b0;
      end else if (hb_cnt_reg == CNT_LAST) begin
         hb_cnt_reg <= '0;
         toggle_reg <= ~toggle_reg;
      end else begin
         hb_cnt_reg <= hb_cnt_reg + CNT_ONE;
      end
   end

   assign idle_led = {~toggle_reg, 3'b111};
`else
   assign idle_led = 4'hF;
`endif

   always_ff @(posedge clk or negedge fpga_reset_n) begin
      if (!fpga_reset_n) begin
         state_reg <= ST_IDLE;
         owner_reg <= '0;
         last_reg  <= IDX_LAST;
         cnt_reg   <= '0;
         grant     <= '0;
         led_n     <= 4'hF;
         busy      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_SWITCH: begin
               if (win_found) begin
                  state_reg <= ST_HOLD;
                  owner_reg <= win_idx;
                  grant     <= onehot(win_idx);
                  busy      <= 1'b1;
                  cnt_reg   <= '0;
                  led_n     <= 4'hF;
               end else begin
                  state_reg <= ST_IDLE;
                  grant     <= '0;
                  busy      <= 1'b0;
                  led_n     <= idle_led;
               end
            end
            ST_HOLD: begin
               if (!req[owner_reg] || (slot_end && others_req)) begin
                  // Hand-over: one blank cycle, then rotation resumes after this owner.
                  state_reg <= ST_SWITCH;
                  last_reg  <= owner_reg;
                  grant     <= '0;
                  busy      <= 1'b0;
                  cnt_reg   <= '0;
                  led_n     <= 4'hF;
               end else begin
                  led_n   <= ~pat[owner_reg];
                  cnt_reg <= slot_end ? '0 : cnt_reg + CNT_ONE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               grant     <= '0;
               busy      <= 1'b0;
               led_n     <= 4'hF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_slot_arbiter.sv
// Randomised and directed bench for led_slot_arbiter against an ownership-level reference model.
module tb_led_slot_arbiter;

   localparam int NREQ = 4;
   localparam int S    = 4;

   logic        clk = 1'b0;
   logic        fpga_reset_n;
   logic [3:0]  req;
   logic [15:0] pattern_in;
   logic [3:0]  grant;
   logic [3:0]  led_n;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: who owns the LEDs (-1 = nobody), how long, and the rotation pointer.
   int          m_owner;
   int          m_last;
   int          m_age;
   int          m_hb;
   bit          m_tog;
   logic [3:0]  m_led;
   logic [3:0]  prev_grant;

   led_slot_arbiter #(.NREQ(NREQ), .SLOT_CYCLES(S)) dut (
      .clk          (clk),
      .fpga_reset_n (fpga_reset_n),
      .req          (req),
      .pattern_in   (pattern_in),
      .grant        (grant),
      .led_n        (led_n),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit expired, got no summary, required completion");
      $fatal(1);
   end

   function automatic int pick(input logic [3:0] r, input int from_last);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(from_last + k) % NREQ]) return (from_last + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_grant();
      return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
   endfunction

   function automatic logic exp_busy();
      return m_owner >= 0;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = NREQ - 1;
      m_age   = 0;
      m_hb    = 0;
      m_tog   = 0;
      m_led   = 4'hF;
   endtask

   task automatic model_step(input logic [3:0] r, input logic [15:0] p);
      logic [3:0] idle_v;
      int w;
      idle_v = 4'hF;
`ifdef LED_SLOT_HEARTBEAT_EN
      idle_v = {~m_tog, 3'b111};
      if (m_hb == S - 1) begin
         m_hb  = 0;
         m_tog = ~m_tog;
      end else begin
         m_hb = m_hb + 1;
      end
`endif
      if (m_owner >= 0) begin
         if (!r[m_owner] || (m_age == S - 1 && (r & ~4'(1 << m_owner)) != 4'b0)) begin
            m_last  = m_owner;
            m_owner = -1;
            m_led   = 4'hF;
         end else begin
            m_led = ~p[4*m_owner +: 4];
            m_age = (m_age + 1) % S;
         end
      end else begin
         w = pick(r, m_last);
         if (w >= 0) begin
            m_owner = w;
            m_age   = 0;
            m_led   = 4'hF;
         end else begin
            m_led = idle_v;
         end
      end
   endtask

   // One clock: the model consumes the inputs the DUT samples, outputs are then read at negedge.
   task automatic tick();
      @(posedge clk);
      if (fpga_reset_n) model_step(req, pattern_in);
      else model_reset();
      @(negedge clk);
      if (grant !== prev_grant)
         $display("[%0t] grant %b led_n %h busy %b req %b", $time, grant, led_n, busy, req);
      prev_grant = grant;
   endtask

   task automatic test_reset();
      fpga_reset_n = 1'b0;
      req          = '0;
      pattern_in   = '0;
      prev_grant   = '0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({grant, led_n, busy} !== {4'b0000, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: got grant=%b led_n=%h busy=%b, required 0000/F/0", grant, led_n, busy);
         end
      end
      fpga_reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({grant, led_n, busy} !== {4'b0000, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_after: got grant=%b led_n=%h busy=%b, required 0000/F/0", grant, led_n, busy);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_seq [16] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                   4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
      req        = 4'b1011;
      pattern_in = 16'(($urandom));
      for (int i = 0; i < 16; i++) begin
         tick();
         vectors++;
         if (grant !== exp_seq[i]) begin
            miscompares++;
            $display("FAIL rr_seq[%0d]: got grant=%b, required %b", i, grant, exp_seq[i]);
         end
         vectors++;
         if ({grant, led_n, busy} !== {exp_grant(), m_led, exp_busy()}) begin
            miscompares++;
            $display("FAIL rr_model[%0d]: got %b/%h/%b, required %b/%h/%b", i, grant, led_n, busy, exp_grant(), m_led, exp_busy());
         end
         pattern_in = 16'($urandom);
      end
      req = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({grant, led_n, busy} !== {exp_grant(), m_led, exp_busy()}) begin
            miscompares++;
            $display("FAIL rr_drain[%0d]: got %b/%h/%b, required %b/%h/%b", i, grant, led_n, busy, exp_grant(), m_led, exp_busy());
         end
      end
   endtask

   task automatic test_single();
      req        = 4'b0100;
      pattern_in = 16'($urandom);
      pattern_in[11:8] = 4'hA;
      tick();
      vectors++;
      if ({grant, busy} !== {4'b0100, 1'b1}) begin
         miscompares++;
         $display("FAIL single_grant: got grant=%b busy=%b, required 0100/1", grant, busy);
      end
      for (int i = 0; i < 21; i++) begin
         tick();
         vectors++;
         if ({grant, led_n} !== {4'b0100, 4'h5}) begin
            miscompares++;
            $display("FAIL single_hold[%0d]: got grant=%b led_n=%h, required 0100/5", i, grant, led_n);
         end
         vectors++;
         if ({grant, led_n, busy} !== {exp_grant(), m_led, exp_busy()}) begin
            miscompares++;
            $display("FAIL single_model[%0d]: got %b/%h/%b, required %b/%h/%b", i, grant, led_n, busy, exp_grant(), m_led, exp_busy());
         end
         pattern_in[7:0]   = 8'($urandom);
         pattern_in[15:12] = 4'($urandom);
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_early_release();
      req = 4'b0101;
      tick();
      vectors++;
      if (grant !== 4'b0001) begin
         miscompares++;
         $display("FAIL early_first: got grant=%b, required 0001", grant);
      end
      tick();
      req = 4'b0100;
      tick();
      vectors++;
      if ({grant, led_n, busy} !== {4'b0000, 4'hF, 1'b0}) begin
         miscompares++;
         $display("FAIL early_blank: got %b/%h/%b, required 0000/F/0", grant, led_n, busy);
      end
      tick();
      vectors++;
      if (grant !== 4'b0100) begin
         miscompares++;
         $display("FAIL early_next: got grant=%b, required 0100", grant);
      end
      vectors++;
      if ({grant, led_n, busy} !== {exp_grant(), m_led, exp_busy()}) begin
         miscompares++;
         $display("FAIL early_model: got %b/%h/%b, required %b/%h/%b", grant, led_n, busy, exp_grant(), m_led, exp_busy());
      end
   endtask

   task automatic test_mid_slot_reset();
      tick();
      tick();
      @(posedge clk);
      model_step(req, pattern_in);
      #2;
      fpga_reset_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({grant, led_n, busy} !== {4'b0000, 4'hF, 1'b0}) begin
         miscompares++;
         $display("FAIL midreset_now: got %b/%h/%b, required 0000/F/0", grant, led_n, busy);
      end
      @(negedge clk);
      prev_grant = grant;
      req = 4'b0110;
      tick();
      tick();
      fpga_reset_n = 1'b1;
      tick();
      vectors++;
      if (grant !== 4'b0010) begin
         miscompares++;
         $display("FAIL midreset_first: got grant=%b, required 0010", grant);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if ({grant, led_n, busy} !== {exp_grant(), m_led, exp_busy()}) begin
            miscompares++;
            $display("FAIL midreset_model[%0d]: got %b/%h/%b, required %b/%h/%b", i, grant, led_n, busy, exp_grant(), m_led, exp_busy());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < NREQ; b++) begin
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         end
         pattern_in = 16'($urandom);
         tick();
         vectors++;
         if ({grant, led_n, busy} !== {exp_grant(), m_led, exp_busy()}) begin
            miscompares++;
            $display("FAIL random[%0d]: req=%b got %b/%h/%b, required %b/%h/%b", i, req, grant, led_n, busy, exp_grant(), m_led, exp_busy());
         end
      end
   endtask

   task automatic test_heartbeat();
      req = '0;
      tick();
      tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         vectors++;
         if ({grant, led_n, busy} !== {exp_grant(), m_led, exp_busy()}) begin
            miscompares++;
            $display("FAIL idle_model[%0d]: got %b/%h/%b, required %b/%h/%b", i, grant, led_n, busy, exp_grant(), m_led, exp_busy());
         end
`ifndef LED_SLOT_HEARTBEAT_EN
         vectors++;
         if (led_n !== 4'hF) begin
            miscompares++;
            $display("FAIL idle_dark[%0d]: got led_n=%h, required F", i, led_n);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_early_release();
      test_mid_slot_reset();
      test_random();
      test_heartbeat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
